block_dispatcher: RTL and testbench
===================================

# block_dispatcher

Kernel-level dispatcher that sits directly upstream of the compute cores. On a kernel launch it splits the total thread count into blocks of `THREADS_PER_BLOCK` threads. It hands each block to a free core by driving `block_id`, `thread_count` and `start` to that core. When the core reports `done`, it pulses a per-core reset and reports kernel completion once every block has retired.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of compute cores served.
- `THREADS_PER_BLOCK`, default 4: threads per block; must match the cores' parameter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: kernel launch pulse; sampled only in IDLE.
- `thread_count_total`, input, 8: total threads in the kernel, 0..255.
- `done`, output, 1: kernel complete; held until the next accepted `start`.
- `core_start`, output, NUM_CORES: per-core start, held high while the core runs a block.
- `core_reset`, output, NUM_CORES: per-core one-cycle reset pulse after a block retires.
- `core_block_id`, output, NUM_CORES × 8: block index assigned to each core.
- `core_thread_count`, output, NUM_CORES × ($clog2(THREADS_PER_BLOCK)+1): active threads in the assigned block.
- `core_done`, input, NUM_CORES: per-core done level from the cores.

## Operation
- States: IDLE and RUN.
- IDLE, `start`=1:
  - Latch `total_blocks` = ceil(`thread_count_total`/`THREADS_PER_BLOCK`) into a 9-bit register, computed from the input in the same cycle.
  - Latch `thread_count_total` into the 8-bit `threads_reg`; this value is used for every remainder calculation below.
  - Clear `blocks_dispatched`, `blocks_done` and `done`.
  - Go to RUN.
- IDLE, `start`=0: hold all outputs.
- Core free: `core_start[i]`=0 and `core_reset[i]`=0.
- Dispatch, RUN, each edge: if `blocks_dispatched` < `total_blocks` and any core is free, pick the lowest-index free core `i` and do the following:
  - Set `core_block_id[i]` = `blocks_dispatched`.
  - Set `core_start[i]`=1.
  - Increment `blocks_dispatched`.
  - At most one dispatch per edge.
- Block thread count: `core_thread_count[i]` = `THREADS_PER_BLOCK`, except for the last block. When `blocks_dispatched` = `total_blocks`-1 and `threads_reg` mod `THREADS_PER_BLOCK` ≠ 0, it is the remainder.
- Retire, RUN, each edge, for every `i` with `core_start[i]`=1 and `core_done[i]`=1:
  - Clear `core_start[i]` and set `core_reset[i]`=1.
  - `blocks_done` increases by the number of cores retiring that edge; several cores may retire on the same edge.
- `core_reset[i]` is always cleared on the edge after it is set.
- Dispatch and retire of different cores on the same edge are both performed.
- A core retiring on edge E is not dispatched on edge E or E+1. It is eligible on edge E+2.
- Completion: in RUN, when `blocks_done` = `total_blocks` at an edge (registered value), set `done`=1 and go to IDLE. `done` stays 1 until the next accepted `start`.
- `thread_count_total`=0 gives `total_blocks`=0: `done` is set on the first RUN edge and no core is started.
- `start` in RUN is ignored, and `thread_count_total` changes in RUN are ignored.
- `core_done[i]` while `core_start[i]`=0 is ignored.
- Widths: `blocks_dispatched` and `blocks_done` are 9 bits, so no wrap occurs for up to 256 blocks.
- Reset (any time, including mid-kernel):
  - State goes to IDLE.
  - `done`, `core_start`, `core_reset`, `core_block_id`, `core_thread_count` and all counters go to 0.
  - In-flight blocks are abandoned.

## Timing
- Edge E0 samples `start`.
- First dispatch is at edge E1: `core_start[0]` is high in the cycle after E1.
- Throughput: one new block per cycle while free cores exist.
- Retire latency: `core_done` is sampled at edge R. `core_start` drops and `core_reset` rises after R. `core_reset` drops after R+1. The core is re-dispatchable at R+2.
- `done` rises one edge after the edge on which the final retire is registered.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- NUM_CORES=2, TPB=4, total=10: E0 launch, then all of the following:
  - E1: core0 gets block 0 with count 4.
  - E2: core1 gets block 1 with count 4.
  - After core0 `done`: `core_reset[0]` pulses for 1 cycle, then core0 gets block 2 with count 2.
  - `done` goes to 1 after block 2 retires.
- Total=8 (exact multiple): two blocks, each with count 4, and no remainder block.
- Total=0: `done`=1 two cycles after `start`, and `core_start` stays 0 throughout.
- Both cores assert `core_done` on the same edge: `blocks_done` increments by 2, and both `core_reset` bits pulse together.
- Assert `reset` mid-kernel with both cores running: all outputs go to 0 immediately (async). A new `start` with total=3 then runs a single block with count 3.
- `start` pulsed while in RUN: no effect on counters, assignments or `done` timing.

Source files
------------

// File: rtl/block_dispatcher.sv
// Kernel-level block dispatcher: splits a launch into fixed-size thread blocks,
// hands them to the lowest-index free core and reports completion when all retire.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [7:0]                                            thread_count_total,
    output logic                                                  done,
    output logic [NUM_CORES-1:0]                                  core_start,
    output logic [NUM_CORES-1:0]                                  core_reset,
    output logic [NUM_CORES*8-1:0]                                core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]    core_thread_count,
    input  logic [NUM_CORES-1:0]                                  core_done
);
    localparam int          CW     = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [8:0]  TPB9   = 9'(THREADS_PER_BLOCK);
    localparam logic [7:0]  TPB8   = 8'(THREADS_PER_BLOCK);
    localparam logic [CW-1:0] TPB_CW = CW'(THREADS_PER_BLOCK);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [8:0]             total_blocks_q, total_blocks_d;
    logic [7:0]             threads_q, threads_d;
    logic [8:0]             dispatched_q, dispatched_d;
    logic [8:0]             retired_q, retired_d;
    logic                   done_q, done_d;
    logic [NUM_CORES-1:0]   core_start_q, core_start_d;
    logic [NUM_CORES-1:0]   core_reset_q, core_reset_d;
    logic [NUM_CORES*8-1:0] block_id_q, block_id_d;
    logic [NUM_CORES*CW-1:0] tcount_q, tcount_d;

    logic [8:0]             total_calc_s;
    logic [CW-1:0]          rem_s;
    logic [CW-1:0]          blk_count_s;
    logic                   dispatched_one_s;

    assign total_calc_s = ({1'b0, thread_count_total} + TPB9 - 9'd1) / TPB9;
    assign rem_s        = CW'(threads_q % TPB8);
    assign blk_count_s  = ((dispatched_q == total_blocks_q - 9'd1) && (rem_s != {CW{1'b0}}))
                          ? rem_s : TPB_CW;

    // Next-state: launch, retire (any number of cores), dispatch (one core), completion
    always_comb begin
        state_d          = state_q;
        total_blocks_d   = total_blocks_q;
        threads_d        = threads_q;
        dispatched_d     = dispatched_q;
        retired_d        = retired_q;
        done_d           = done_q;
        core_start_d     = core_start_q;
        core_reset_d     = {NUM_CORES{1'b0}};
        block_id_d       = block_id_q;
        tcount_d         = tcount_q;
        dispatched_one_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    total_blocks_d = total_calc_s;
                    threads_d      = thread_count_total;
                    dispatched_d   = 9'd0;
                    retired_d      = 9'd0;
                    done_d         = 1'b0;
                    state_d        = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (core_start_q[i] && core_done[i]) begin
                        core_start_d[i] = 1'b0;
                        core_reset_d[i] = 1'b1;
                        retired_d       = retired_d + 9'd1;
                    end else begin
                        core_reset_d[i] = 1'b0;
                    end
                end
                // A core still in its reset pulse is not free, giving the E+2 re-dispatch
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (!dispatched_one_s && (dispatched_q < total_blocks_q) &&
                        !core_start_q[i] && !core_reset_q[i]) begin
                        dispatched_one_s       = 1'b1;
                        core_start_d[i]        = 1'b1;
                        block_id_d[i*8 +: 8]   = dispatched_q[7:0];
                        tcount_d[i*CW +: CW]   = blk_count_s;
                        dispatched_d           = dispatched_q + 9'd1;
                    end else begin
                        dispatched_one_s = dispatched_one_s;
                    end
                end
                if (retired_q == total_blocks_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            total_blocks_q <= 9'd0;
            threads_q      <= 8'd0;
            dispatched_q   <= 9'd0;
            retired_q      <= 9'd0;
            done_q         <= 1'b0;
            core_start_q   <= {NUM_CORES{1'b0}};
            core_reset_q   <= {NUM_CORES{1'b0}};
            block_id_q     <= {(NUM_CORES*8){1'b0}};
            tcount_q       <= {(NUM_CORES*CW){1'b0}};
        end else begin
            state_q        <= state_d;
            total_blocks_q <= total_blocks_d;
            threads_q      <= threads_d;
            dispatched_q   <= dispatched_d;
            retired_q      <= retired_d;
            done_q         <= done_d;
            core_start_q   <= core_start_d;
            core_reset_q   <= core_reset_d;
            block_id_q     <= block_id_d;
            tcount_q       <= tcount_d;
        end
    end

    assign done              = done_q;
    assign core_start        = core_start_q;
    assign core_reset        = core_reset_q;
    assign core_block_id     = block_id_q;
    assign core_thread_count = tcount_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (2 cores, 4 threads per block).
module tb_block_dispatcher;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  thread_count_total;
    logic        done;
    logic [1:0]  core_start;
    logic [1:0]  core_reset;
    logic [15:0] core_block_id;
    logic [5:0]  core_thread_count;
    logic [1:0]  core_done;

    int checks = 0;
    int errors = 0;

    block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count_total(thread_count_total),
        .done              (done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .core_done         (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_count_total = 8'd0; core_done = 2'b00;
        step();
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_creset", 32'(core_reset), 32'd0);
        chk("rst_bid",   32'(core_block_id), 32'd0);
        chk("rst_tc",    32'(core_thread_count), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_hold", 32'(core_start), 32'd0);

        // total=10: blocks 4,4,2
        start = 1'b1; thread_count_total = 8'd10;
        step();
        start = 1'b0;
        chk("t10_e0_start", 32'(core_start), 32'd0);
        step();
        chk("t10_e1_start", 32'(core_start), 32'b01);
        chk("t10_e1_bid0",  32'(core_block_id[7:0]), 32'd0);
        chk("t10_e1_tc0",   32'(core_thread_count[2:0]), 32'd4);
        step();
        chk("t10_e2_start", 32'(core_start), 32'b11);
        chk("t10_e2_bid1",  32'(core_block_id[15:8]), 32'd1);
        chk("t10_e2_tc1",   32'(core_thread_count[5:3]), 32'd4);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t10_r_start",  32'(core_start), 32'b10);
        chk("t10_r_creset", 32'(core_reset), 32'b01);
        step();
        chk("t10_r1_creset", 32'(core_reset), 32'b00);
        chk("t10_r1_start",  32'(core_start), 32'b10);
        step();
        chk("t10_r2_start", 32'(core_start), 32'b11);
        chk("t10_r2_bid0",  32'(core_block_id[7:0]), 32'd2);
        chk("t10_r2_tc0",   32'(core_thread_count[2:0]), 32'd2);
        chk("t10_r2_done",  32'(done), 32'd0);
        core_done = 2'b10;
        step();
        core_done = 2'b00;
        chk("t10_c1_start",  32'(core_start), 32'b01);
        chk("t10_c1_creset", 32'(core_reset), 32'b10);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t10_c0_start", 32'(core_start), 32'b00);
        chk("t10_c0_done",  32'(done), 32'd0);
        step();
        chk("t10_done",      32'(done), 32'd1);
        chk("t10_done_crst", 32'(core_reset), 32'b00);
        step();
        chk("t10_done_hold", 32'(done), 32'd1);

        // total=8 with a stray start during RUN: two full blocks only
        start = 1'b1; thread_count_total = 8'd8;
        step();
        chk("t8_e0_done", 32'(done), 32'd0);
        start = 1'b1; thread_count_total = 8'd100;
        step();
        start = 1'b0; thread_count_total = 8'd0;
        chk("t8_e1_start", 32'(core_start), 32'b01);
        chk("t8_e1_bid0",  32'(core_block_id[7:0]), 32'd0);
        chk("t8_e1_tc0",   32'(core_thread_count[2:0]), 32'd4);
        step();
        chk("t8_e2_start", 32'(core_start), 32'b11);
        chk("t8_e2_bid1",  32'(core_block_id[15:8]), 32'd1);
        chk("t8_e2_tc1",   32'(core_thread_count[5:3]), 32'd4);
        core_done = 2'b11;
        step();
        core_done = 2'b00;
        chk("t8_both_start",  32'(core_start), 32'b00);
        chk("t8_both_creset", 32'(core_reset), 32'b11);
        step();
        chk("t8_done",       32'(done), 32'd1);
        chk("t8_no_third",   32'(core_start), 32'b00);
        chk("t8_creset_clr", 32'(core_reset), 32'b00);

        // total=0: immediate completion, no core started
        start = 1'b1; thread_count_total = 8'd0;
        step();
        start = 1'b0;
        chk("t0_e0_done",  32'(done), 32'd0);
        chk("t0_e0_start", 32'(core_start), 32'b00);
        step();
        chk("t0_e1_done",  32'(done), 32'd1);
        chk("t0_e1_start", 32'(core_start), 32'b00);

        // total=12, async reset with both cores running
        start = 1'b1; thread_count_total = 8'd12;
        step();
        start = 1'b0;
        step();
        step();
        chk("t12_running", 32'(core_start), 32'b11);
        reset = 1'b1;
        #1;
        chk("arst_start",  32'(core_start), 32'd0);
        chk("arst_done",   32'(done), 32'd0);
        chk("arst_bid",    32'(core_block_id), 32'd0);
        chk("arst_tc",     32'(core_thread_count), 32'd0);
        #3;
        reset = 1'b0;
        step();
        start = 1'b1; thread_count_total = 8'd3;
        step();
        start = 1'b0;
        step();
        chk("t3_e1_start", 32'(core_start), 32'b01);
        chk("t3_e1_bid0",  32'(core_block_id[7:0]), 32'd0);
        chk("t3_e1_tc0",   32'(core_thread_count[2:0]), 32'd3);
        step();
        chk("t3_single",   32'(core_start), 32'b01);
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        chk("t3_creset",   32'(core_reset), 32'b01);
        chk("t3_pre_done", 32'(done), 32'd0);
        step();
        chk("t3_done",     32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
